// File: rtl/intersection_phase_scheduler.sv
// Round-robin green-phase scheduler for an N-approach intersection.
// Optional EMERGENCY_PREEMPT_EN adds preempt/preempt_idx override inputs.
module intersection_phase_scheduler #(
  parameter int N_APPR       = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_MIN    = 8,
  parameter int GREEN_MAX    = 16,
  parameter int YELLOW_T     = 4,
  parameter int ALLRED_T     = 2,
  parameter int DEFAULT_APPR = 0,
  localparam int IDX_W       = $clog2(N_APPR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [N_APPR-1:0]   sensor,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                preempt,
  input  logic [IDX_W-1:0]    preempt_idx,
`endif
  output logic [3*N_APPR-1:0] lights,
  output logic [N_APPR-1:0]   grant,
  output logic [N_APPR-1:0]   pending
);

  typedef enum logic [1:0] {
    S_ALLRED,
    S_GREEN,
    S_YELLOW
  } state_e;

  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] GN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_APPR);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [N_APPR-1:0]   pending_q, pending_d;
  logic [N_APPR-1:0]   grant_q, grant_d;
  logic [3*N_APPR-1:0] lights_q, lights_d;

  logic [N_APPR-1:0]   ign;
  logic [IDX_W-1:0]    next_idx;
  logic                found;
  logic                go;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cur_d     = cur_q;
    ign       = '0;
    next_idx  = DEF_IDX;
    found     = 1'b0;
    go        = 1'b0;
    lights_d  = '0;
    grant_d   = '0;

    if (state_q == S_GREEN) begin
      ign[cur_q] = 1'b1;
    end
    pending_d = pending_q | (sensor & ~ign);

    // Scan starts just past cur and wraps back to cur last.
    for (int i = 1; i <= N_APPR; i++) begin
      if (!found && pending_q[(int'(cur_q) + i) % N_APPR]) begin
        next_idx = IDX_W'((int'(cur_q) + i) % N_APPR);
        found    = 1'b1;
      end
    end
`ifdef EMERGENCY_PREEMPT_EN
    if (preempt) begin
      next_idx = preempt_idx;
    end
`endif

    unique case (state_q)
      S_ALLRED: go = tick && (timer_q == AR_LAST);
      S_GREEN: begin
        if (cur_q == DEF_IDX) begin
          go = tick && (timer_q >= GN_LAST) && (|pending_q);
        end else begin
          go = tick && (timer_q >= GX_LAST);
        end
`ifdef EMERGENCY_PREEMPT_EN
        if (preempt) begin
          go = (cur_q != preempt_idx);
        end
`endif
      end
      S_YELLOW: go = tick && (timer_q == Y_LAST);
      default:  go = 1'b0;
    endcase

    if (go) begin
      timer_d = '0;
      unique case (state_q)
        S_ALLRED: begin
          state_d             = S_GREEN;
          cur_d               = next_idx;
          pending_d[next_idx] = 1'b0;
        end
        S_GREEN:  state_d = S_YELLOW;
        default:  state_d = S_ALLRED;
      endcase
    end else if (tick && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end

    for (int i = 0; i < N_APPR; i++) begin
      lights_d[3*i +: 3] = 3'b100;
      if (state_d != S_ALLRED && cur_d == IDX_W'(i)) begin
        grant_d[i]         = 1'b1;
        lights_d[3*i +: 3] = (state_d == S_GREEN) ? 3'b001 : 3'b010;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ALLRED;
      timer_q   <= '0;
      cur_q     <= DEF_IDX;
      pending_q <= '0;
      grant_q   <= '0;
      lights_q  <= {N_APPR{3'b100}};
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      lights_q  <= lights_d;
    end
  end

  assign lights  = lights_q;
  assign grant   = grant_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Randomized bench for intersection_phase_scheduler against a
// phase-level reference model with default parameters.
module tb_intersection_phase_scheduler;

  localparam int N  = 4;
  localparam int GN = 8;
  localparam int GX = 16;
  localparam int YT = 4;
  localparam int AT = 2;
  localparam int DF = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [N-1:0]  sensor;
  logic [3*N-1:0] lights;
  logic [N-1:0]  grant;
  logic [N-1:0]  pending;
`ifdef EMERGENCY_PREEMPT_EN
  logic          preempt = 1'b0;
  logic [1:0]    preempt_idx = 2'd0;
`endif

  intersection_phase_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .sensor  (sensor),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt     (preempt),
    .preempt_idx (preempt_idx),
`endif
    .lights  (lights),
    .grant   (grant),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: phase 0=all-red, 1=green, 2=yellow; el = ticks spent in phase.
  int       ph;
  int       el;
  int       mc;
  bit [N-1:0] mp;

  task automatic m_step(input bit rst, input bit tk, input bit [N-1:0] sn);
    bit [N-1:0] np;
    bit leave;
    int nx;
    if (rst) begin
      ph = 0; el = 0; mc = DF; mp = '0;
      return;
    end
    np = mp | sn;
    if (ph == 1) np[mc] = mp[mc];
    leave = 0;
    case (ph)
      0: leave = tk && el == AT - 1;
      1: if (mc == DF) leave = tk && el >= GN - 1 && mp != 0;
         else          leave = tk && el >= GX - 1;
      default: leave = tk && el == YT - 1;
    endcase
    if (leave) begin
      el = 0;
      if (ph == 0) begin
        nx = DF;
        for (int k = N; k >= 1; k--)
          if (mp[(mc + k) % N]) nx = (mc + k) % N;
        mc = nx;
        np[nx] = 1'b0;
        ph = 1;
      end else begin
        ph = (ph == 1) ? 2 : 0;
      end
    end else if (tk && el < 255) begin
      el++;
    end
    mp = np;
  endtask

  function automatic logic [3*N-1:0] m_lights();
    logic [3*N-1:0] l;
    for (int i = 0; i < N; i++) begin
      l[3*i +: 3] = 3'b100;
      if (ph != 0 && i == mc) l[3*i +: 3] = (ph == 1) ? 3'b001 : 3'b010;
    end
    return l;
  endfunction

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g = '0;
    if (ph != 0) g[mc] = 1'b1;
    return g;
  endfunction

  task automatic cycle(input bit rst, input bit tk, input bit [N-1:0] sn);
    reset  = rst;
    tick   = tk;
    sensor = sn;
    m_step(rst, tk, sn);
    @(negedge clk);
    chk("lights",  32'(lights),  32'(m_lights()));
    chk("grant",   32'(grant),   32'(m_grant()));
    chk("pending", 32'(pending), 32'(mp));
  endtask

  int nonred;

  initial begin
    reset = 1'b1; tick = 1'b1; sensor = '0;
    ph = 0; el = 0; mc = DF; mp = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1, 1, '0);
    chk("rst_lights", 32'(lights), 32'h924);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    cycle(0, 1, '0);
    chk("ar1", 32'(lights), 32'h924);
    cycle(0, 1, '0);
    chk("g0_lights", 32'(lights), 32'h921);
    chk("g0_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 40; i++) cycle(0, 1, '0);
    chk("g0_hold", 32'(lights), 32'h921);
    cycle(0, 1, 4'b0100);
    chk("p2", 32'(pending), 32'h4);
    cycle(0, 1, '0);
    chk("y0", 32'(lights), 32'h922);
    for (int i = 0; i < 60; i++) cycle(0, 1, '0);
    cycle(0, 1, 4'b1010);
    chk("p1010", 32'(pending), 32'ha);
    for (int i = 0; i < 8; i++) cycle(0, 1, '0);
    chk("p1000", 32'(pending), 32'h8);
    for (int i = 0; i < 20000; i++) begin
      cycle($urandom_range(0, 999) == 0,
            $urandom_range(0, 9) < 8,
            {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)});
      nonred = 0;
      for (int k = 0; k < N; k++)
        if (lights[3*k +: 3] != 3'b100) nonred++;
      if (nonred > 1) chk("one_nonred", 32'(nonred), 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
